// File: rtl/matrix_keypad_entry.sv
// Matrix keypad scanner with press/release debounce and a decimal entry buffer.
// One row is driven low at a time; a low column starts a press debounce on the
// frozen row. Each debounced single-key press produces exactly one key event
// that edits the entry buffer (digits, backspace, clear, enter).
module matrix_keypad_entry #(
    parameter int                     ROWS        = 4,
    parameter int                     COLS        = 4,
    parameter int                     SCAN_PERIOD = 2_000_000,
    parameter int                     DEBOUNCE    = 2_000_000,
    parameter int                     MAX_DIGITS  = 4,
    parameter int                     DATA_W      = 14,
    parameter logic [ROWS*COLS*4-1:0] KEYMAP      = 64'hFF0F_C987_B654_A321
) (
    input  logic                                 sys_clk,
    input  logic                                 sys_rst_n,
    input  logic [COLS-1:0]                      col,
    input  logic                                 ack,
    output logic [ROWS-1:0]                      row,
    output logic                                 key_valid,
    output logic [3:0]                           key_code,
    output logic [DATA_W-1:0]                    value,
    output logic [$clog2(MAX_DIGITS+1)-1:0]      digit_cnt,
    output logic [DATA_W-1:0]                    result,
    output logic                                 result_valid,
    output logic                                 overflow
);

    localparam int KEYS    = ROWS * COLS;
    localparam int RIDX_W  = $clog2(ROWS);
    localparam int CIDX_W  = $clog2(COLS);
    localparam int KIDX_W  = $clog2(KEYS);
    localparam int TMR_MAX = (SCAN_PERIOD > DEBOUNCE) ? SCAN_PERIOD : DEBOUNCE;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int CNT_W   = $clog2(MAX_DIGITS + 1);

    localparam logic [3:0] CODE_BKSP  = 4'hA;
    localparam logic [3:0] CODE_CLEAR = 4'hB;
    localparam logic [3:0] CODE_ENTER = 4'hC;

    typedef enum logic [1:0] {
        SCAN,
        PRESS_DB,
        HELD,
        RELEASE_DB
    } state_t;

    state_t            state, state_nxt;
    logic [RIDX_W-1:0] row_idx, row_idx_nxt, row_adv;
    logic [TMR_W-1:0]  tmr, tmr_nxt;
    logic [COLS-1:0]   col_cap, col_cap_nxt;
    logic              key_fire;

    logic              single_low;
    logic [CIDX_W-1:0] col_idx;
    logic [KIDX_W-1:0] key_idx;
    logic [3:0]        key_sel;
    logic [3:0]        code_tbl [KEYS];
    logic [DATA_W-1:0] value_push;

    // One-cold row drive follows the registered row index, so reset acts on it at once.
    assign row     = ~(ROWS'(1) << row_idx);
    assign row_adv = (row_idx == RIDX_W'(ROWS - 1)) ? '0 : row_idx + RIDX_W'(1);

    // Unpack the flat keymap into a per-key code table.
    for (genvar g = 0; g < KEYS; g++) begin : g_code
        assign code_tbl[g] = KEYMAP[4*g +: 4];
    end

    // Decode the captured column pattern into a column index (valid when single_low).
    always_comb begin
        col_idx = '0;
        for (int c = 0; c < COLS; c++) begin
            if (!col_cap[c]) col_idx = CIDX_W'(c);
        end
    end

    assign single_low = $onehot(~col_cap);
    assign key_idx    = KIDX_W'(row_idx) * KIDX_W'(COLS) + KIDX_W'(col_idx);
    assign key_sel    = code_tbl[key_idx];
    // Fits in DATA_W because a digit is only appended while fewer than MAX_DIGITS are held.
    assign value_push = value * DATA_W'(10) + DATA_W'(key_sel);

    // Scanner state, row index, shared scan/debounce timer and captured columns.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state   <= SCAN;
            row_idx <= '0;
            tmr     <= '0;
            col_cap <= '1;
        end else begin
            state   <= state_nxt;
            row_idx <= row_idx_nxt;
            tmr     <= tmr_nxt;
            col_cap <= col_cap_nxt;
        end
    end

    // Next-state logic: scan rotation, press debounce, hold, release debounce.
    // NOTE: every signal gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_nxt   = state;
        row_idx_nxt = row_idx;
        tmr_nxt     = tmr;
        col_cap_nxt = col_cap;
        key_fire    = 1'b0;
        unique case (state)
            SCAN: begin
                if (col != '1) begin
                    col_cap_nxt = col;
                    tmr_nxt     = '0;
                    state_nxt   = PRESS_DB;
                end else if (tmr == TMR_W'(SCAN_PERIOD - 1)) begin
                    tmr_nxt     = '0;
                    row_idx_nxt = row_adv;
                end else begin
                    tmr_nxt = tmr + TMR_W'(1);
                end
            end
            PRESS_DB: begin
                // The capture cycle starts the window; DEBOUNCE matching cycles follow.
                if (col != col_cap) begin
                    tmr_nxt   = '0;
                    state_nxt = SCAN;
                end else if (tmr == TMR_W'(DEBOUNCE - 1)) begin
                    tmr_nxt   = '0;
                    state_nxt = HELD;
                    key_fire  = single_low;  // multi-key patterns are ghosts: no event
                end else begin
                    tmr_nxt = tmr + TMR_W'(1);
                end
            end
            HELD: begin
                if (col == '1) begin
                    tmr_nxt   = '0;
                    state_nxt = RELEASE_DB;
                end
            end
            RELEASE_DB: begin
                if (col != '1) begin
                    tmr_nxt   = '0;
                    state_nxt = HELD;
                end else if (tmr == TMR_W'(DEBOUNCE - 1)) begin
                    tmr_nxt     = '0;
                    row_idx_nxt = row_adv;
                    state_nxt   = SCAN;
                end else begin
                    tmr_nxt = tmr + TMR_W'(1);
                end
            end
            default: state_nxt = SCAN;
        endcase
    end

    // Key event outputs and entry buffer; ack overrides any same-cycle buffer action.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            key_valid    <= 1'b0;
            key_code     <= 4'h0;
            value        <= '0;
            digit_cnt    <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            key_valid    <= key_fire;
            result_valid <= 1'b0;
            overflow     <= 1'b0;
            if (key_fire) key_code <= key_sel;

            if (ack) begin
                value     <= '0;
                digit_cnt <= '0;
            end else if (key_fire) begin
                if (key_sel <= 4'd9) begin
                    if (digit_cnt < CNT_W'(MAX_DIGITS)) begin
                        value     <= value_push;
                        digit_cnt <= digit_cnt + CNT_W'(1);
                    end else begin
                        overflow <= 1'b1;
                    end
                end else if (key_sel == CODE_BKSP) begin
                    if (digit_cnt != '0) begin
                        value     <= value / DATA_W'(10);
                        digit_cnt <= digit_cnt - CNT_W'(1);
                    end
                end else if (key_sel == CODE_CLEAR) begin
                    value     <= '0;
                    digit_cnt <= '0;
                end else if (key_sel == CODE_ENTER) begin
                    result       <= value;
                    result_valid <= 1'b1;
                    value        <= '0;
                    digit_cnt    <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_matrix_keypad_entry.sv
// Directed bench for matrix_keypad_entry with a small keypad model driving col
// from the DUT's row drive. SCAN_PERIOD=4, DEBOUNCE=3.
module tb_matrix_keypad_entry;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [3:0]  col;
    logic        ack = 1'b0;
    logic [3:0]  row;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [13:0] value;
    logic [2:0]  digit_cnt;
    logic [13:0] result;
    logic        result_valid;
    logic        overflow;

    // Keypad model: a pressed key pulls its column pattern low while its row is driven.
    logic        press_en = 1'b0;
    int          press_r = 0;
    logic [3:0]  press_cols = 4'b1111;
    logic        force_en = 1'b0;
    logic [3:0]  force_val = 4'b1111;

    int checks = 0;
    int errors = 0;
    int kv_total = 0;
    int rv_total = 0;
    int ov_total = 0;
    int kv0, rv0, ov0;
    logic [3:0] exp_row;

    assign col = force_en ? force_val
               : ((press_en && row[press_r] == 1'b0) ? press_cols : 4'b1111);

    matrix_keypad_entry #(
        .SCAN_PERIOD(4),
        .DEBOUNCE   (3)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .col         (col),
        .ack         (ack),
        .row         (row),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .value       (value),
        .digit_cnt   (digit_cnt),
        .result      (result),
        .result_valid(result_valid),
        .overflow    (overflow)
    );

    always #5 sys_clk = ~sys_clk;

    // Pulse counters sampled away from the active edge.
    always @(negedge sys_clk) begin
        if (key_valid === 1'b1) kv_total++;
        if (result_valid === 1'b1) rv_total++;
        if (overflow === 1'b1) ov_total++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Press a key long enough for the scan to reach it, then release cleanly.
    task automatic press_key(input int r, input logic [3:0] cm);
        press_r    = r;
        press_cols = cm;
        press_en   = 1'b1;
        repeat (30) @(negedge sys_clk);
        press_en = 1'b0;
        repeat (10) @(negedge sys_clk);
    endtask

    task automatic pulse_reset();
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_row"}, row, 4'b1110);
        check({tag, "_key_valid"}, key_valid, 1'b0);
        check({tag, "_key_code"}, key_code, 4'h0);
        check({tag, "_value"}, value, 14'd0);
        check({tag, "_digit_cnt"}, digit_cnt, 3'd0);
        check({tag, "_result"}, result, 14'd0);
        check({tag, "_result_valid"}, result_valid, 1'b0);
        check({tag, "_overflow"}, overflow, 1'b0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge sys_clk);
        check_reset_outputs("reset");

        // Idle scan: each row held 4 cycles, rotating 0,1,2,3,0
        sys_rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            exp_row = ~(4'b0001 << ((i / 4) % 4));
            check("scan_row", row, exp_row);
            @(negedge sys_clk);
        end

        // 1,2,3 then enter -> result 123
        kv0 = kv_total;
        press_key(0, 4'b1110);
        check("d1_value", value, 14'd1);
        check("d1_cnt", digit_cnt, 3'd1);
        check("d1_code", key_code, 4'h1);
        press_key(0, 4'b1101);
        check("d2_value", value, 14'd12);
        press_key(0, 4'b1011);
        check("d3_value", value, 14'd123);
        check("d3_cnt", digit_cnt, 3'd3);
        rv0 = rv_total;
        press_key(2, 4'b0111);
        check("enter_result", result, 14'd123);
        check("enter_value", value, 14'd0);
        check("enter_cnt", digit_cnt, 3'd0);
        check("enter_code", key_code, 4'hC);
        check("enter_rv_pulses", rv_total - rv0, 1);
        check("enter_kv_pulses", kv_total - kv0, 4);

        // 9,8,7,6,5 -> 9876 with one overflow; backspace -> 987
        kv0 = kv_total;
        ov0 = ov_total;
        press_key(2, 4'b1011);
        press_key(2, 4'b1101);
        press_key(2, 4'b1110);
        press_key(1, 4'b1011);
        press_key(1, 4'b1101);
        check("ovf_value", value, 14'd9876);
        check("ovf_cnt", digit_cnt, 3'd4);
        check("ovf_pulses", ov_total - ov0, 1);
        check("ovf_kv_pulses", kv_total - kv0, 5);
        press_key(0, 4'b0111);
        check("bksp_value", value, 14'd987);
        check("bksp_cnt", digit_cnt, 3'd3);

        // Ignored code F: event only
        kv0 = kv_total;
        press_key(3, 4'b1110);
        check("keyf_code", key_code, 4'hF);
        check("keyf_value", value, 14'd987);
        check("keyf_kv", kv_total - kv0, 1);

        // Clear, backspace on empty, enter on empty
        press_key(1, 4'b0111);
        check("clear_value", value, 14'd0);
        check("clear_cnt", digit_cnt, 3'd0);
        press_key(0, 4'b0111);
        check("bksp_empty_value", value, 14'd0);
        check("bksp_empty_cnt", digit_cnt, 3'd0);
        rv0 = rv_total;
        press_key(2, 4'b0111);
        check("enter_empty_result", result, 14'd0);
        check("enter_empty_rv", rv_total - rv0, 1);

        // Two-cycle glitch from a known scan position: abort keeps row, clears timer
        pulse_reset();
        force_en  = 1'b1;
        force_val = 4'b1110;
        kv0 = kv_total;
        @(negedge sys_clk);
        @(negedge sys_clk);
        force_val = 4'b1111;
        @(negedge sys_clk);
        check("glitch_row_kept", row, 4'b1110);
        repeat (4) @(negedge sys_clk);
        check("glitch_row_adv", row, 4'b1101);
        force_en = 1'b0;
        check("glitch_kv", kv_total - kv0, 0);

        // Bounce during release -> single event
        kv0 = kv_total;
        press_r    = 2;
        press_cols = 4'b1110;
        press_en   = 1'b1;
        repeat (30) @(negedge sys_clk);
        press_en = 1'b0;
        @(negedge sys_clk);
        press_en = 1'b1;
        @(negedge sys_clk);
        press_en = 1'b0;
        repeat (2) @(negedge sys_clk);
        press_en = 1'b1;
        @(negedge sys_clk);
        press_en = 1'b0;
        repeat (10) @(negedge sys_clk);
        check("bounce_kv", kv_total - kv0, 1);
        check("bounce_value", value, 14'd7);
        check("bounce_cnt", digit_cnt, 3'd1);

        // Two columns low on one row -> ghost, no event
        kv0 = kv_total;
        press_key(1, 4'b1001);
        check("ghost_kv", kv_total - kv0, 0);
        check("ghost_value", value, 14'd7);

        // ack while idle clears buffer
        ack = 1'b1;
        @(negedge sys_clk);
        ack = 1'b0;
        check("ack_value", value, 14'd0);
        check("ack_cnt", digit_cnt, 3'd0);

        // ack coincident with digit 5 acceptance (fires at 8th edge after reset release)
        pulse_reset();
        press_r    = 1;
        press_cols = 4'b1101;
        press_en   = 1'b1;
        repeat (7) @(negedge sys_clk);
        ack = 1'b1;
        @(negedge sys_clk);
        ack = 1'b0;
        check("ackkey_kv", key_valid, 1'b1);
        check("ackkey_code", key_code, 4'h5);
        check("ackkey_value", value, 14'd0);
        check("ackkey_cnt", digit_cnt, 3'd0);
        check("ackkey_rv", result_valid, 1'b0);
        check("ackkey_ovf", overflow, 1'b0);
        @(negedge sys_clk);
        check("ackkey_kv_single", key_valid, 1'b0);
        press_en = 1'b0;
        repeat (10) @(negedge sys_clk);

        // Reset during HELD with value 42
        pulse_reset();
        press_key(1, 4'b1110);
        press_key(2, 4'b0111);
        check("pre_result", result, 14'd4);
        press_key(1, 4'b1110);
        press_r    = 0;
        press_cols = 4'b1101;
        press_en   = 1'b1;
        repeat (30) @(negedge sys_clk);
        check("held_value", value, 14'd42);
        kv0 = kv_total;
        sys_rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_held");
        press_en = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        check("rst_rel_row", row, 4'b1110);
        repeat (20) @(negedge sys_clk);
        check("rst_rel_kv", kv_total - kv0, 0);
        check("rst_rel_value", value, 14'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
